fifo_rptr_empty: RTL and testbench

//  Read-side controller of the dual-clock FIFO, running entirely in the r_clk domain.
//  - Receives the gray-coded write pointer from the w_clk domain and synchronises it.
//  - Produces the read address for the dual-port RAM and the gray read pointer for the write side.
//  - Produces the registered empty / almost-empty flags and the read-side fill level.
//  - Counterpart of the write-pointer/full controller. Its r_addr and r_empty drive the FIFO memory.

---
 rtl/fifo_rptr_empty.sv | 74 +++++++
 tb/tb_fifo_rptr_empty.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rptr_empty.sv
// rtl/fifo_rptr_empty.sv - read-pointer/empty controller of the dual-clock FIFO (r_clk domain)
// Synchronises the gray write pointer, advances the read pointer and registers the flags and fill level.
module fifo_rptr_empty #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_en,
  input  logic [ADDR_W:0]   w_gptr,
  output logic [ADDR_W-1:0] r_addr,
  output logic [ADDR_W:0]   r_gptr,
  output logic              r_empty,
  output logic              r_almost_empty,
  output logic [ADDR_W:0]   r_level
);

  logic [ADDR_W:0] rq1_wgptr_q, rq1_wgptr_d;
  logic [ADDR_W:0] rq2_wgptr_q, rq2_wgptr_d;
  logic [ADDR_W:0] r_bin_q, r_bin_d;
  logic [ADDR_W:0] r_gptr_q, r_gptr_d;
  logic [ADDR_W:0] r_level_q, r_level_d;
  logic            r_empty_q, r_empty_d;
  logic            r_almost_empty_q, r_almost_empty_d;
  logic            rd_ok;
  logic [ADDR_W:0] w_bin_s;

  always_comb begin
    rq1_wgptr_d = w_gptr;
    rq2_wgptr_d = rq1_wgptr_q;

    rd_ok    = r_en & ~r_empty_q;
    r_bin_d  = r_bin_q + {{ADDR_W{1'b0}}, rd_ok};
    r_gptr_d = r_bin_d ^ (r_bin_d >> 1);

    // Gray-to-binary: each bit is the XOR of all gray bits at or above it.
    w_bin_s = '0;
    for (int i = 0; i <= int'(ADDR_W); i++) begin
      w_bin_s[i] = ^(rq2_wgptr_q >> i);
    end

    // Flags look at the post-read pointer so the last read empties on the same edge.
    r_level_d        = w_bin_s - r_bin_d;
    r_empty_d        = (r_gptr_d == rq2_wgptr_q);
    r_almost_empty_d = ({{(31 - ADDR_W){1'b0}}, r_level_d} <= AE_THRESH);
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rq1_wgptr_q      <= '0;
      rq2_wgptr_q      <= '0;
      r_bin_q          <= '0;
      r_gptr_q         <= '0;
      r_level_q        <= '0;
      r_empty_q        <= 1'b1;
      r_almost_empty_q <= 1'b1;
    end else begin
      rq1_wgptr_q      <= rq1_wgptr_d;
      rq2_wgptr_q      <= rq2_wgptr_d;
      r_bin_q          <= r_bin_d;
      r_gptr_q         <= r_gptr_d;
      r_level_q        <= r_level_d;
      r_empty_q        <= r_empty_d;
      r_almost_empty_q <= r_almost_empty_d;
    end
  end

  assign r_addr         = r_bin_q[ADDR_W-1:0];
  assign r_gptr         = r_gptr_q;
  assign r_empty        = r_empty_q;
  assign r_almost_empty = r_almost_empty_q;
  assign r_level        = r_level_q;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// tb/tb_fifo_rptr_empty.sv - directed self-checking bench for fifo_rptr_empty
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_fifo_rptr_empty;

  logic       r_clk = 1'b0;
  logic       r_rst;
  logic       r_en;
  logic [4:0] w_gptr;
  logic [3:0] r_addr;
  logic [4:0] r_gptr;
  logic       r_empty;
  logic       r_almost_empty;
  logic [4:0] r_level;

  int checks   = 0;
  int failures = 0;

  fifo_rptr_empty #(.ADDR_W(4), .AE_THRESH(2)) dut (
    .r_clk          (r_clk),
    .r_rst          (r_rst),
    .r_en           (r_en),
    .w_gptr         (w_gptr),
    .r_addr         (r_addr),
    .r_gptr         (r_gptr),
    .r_empty        (r_empty),
    .r_almost_empty (r_almost_empty),
    .r_level        (r_level)
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic do_reset();
    r_rst  = 1'b1;
    r_en   = 1'b0;
    w_gptr = 5'd0;
    tick();
    tick();
    r_rst = 1'b0;
  endtask

  logic [4:0] wb;
  logic [3:0] prev_addr;
  logic [4:0] prev_gptr;
  bit         addr_wrapped;
  bit         gptr_wrapped;
  int         bad_level;
  int         bad_empty;

  initial begin
    // 1 reset
    do_reset();
    check("rst_empty", r_empty, 1);
    check("rst_ae", r_almost_empty, 1);
    check("rst_level", r_level, 0);
    check("rst_addr", r_addr, 0);
    check("rst_gptr", r_gptr, 0);

    // 2 single write then single read
    w_gptr = 5'b00001;
    tick();
    check("sw_empty_e1", r_empty, 1);
    tick();
    check("sw_empty_e2", r_empty, 1);
    tick();
    check("sw_empty_e3", r_empty, 0);
    check("sw_level", r_level, 1);
    check("sw_ae", r_almost_empty, 1);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    check("sr_addr", r_addr, 1);
    check("sr_gptr", r_gptr, 5'b00001);
    check("sr_empty", r_empty, 1);
    check("sr_level", r_level, 0);

    // 3 full, then 14 reads
    do_reset();
    w_gptr = 5'b11000;
    tick();
    tick();
    tick();
    check("full_level", r_level, 16);
    check("full_ae", r_almost_empty, 0);
    check("full_empty", r_empty, 0);
    r_en = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    r_en = 1'b0;
    check("r14_level", r_level, 2);
    check("r14_ae", r_almost_empty, 1);
    check("r14_addr", r_addr, 14);

    // 4 drain then underflow attempts
    r_en = 1'b1;
    tick();
    tick();
    check("drain_empty", r_empty, 1);
    check("drain_addr", r_addr, 0);
    for (int i = 0; i < 5; i++) tick();
    r_en = 1'b0;
    check("uf_addr", r_addr, 0);
    check("uf_gptr", r_gptr, 5'b11000);
    check("uf_level", r_level, 0);
    check("uf_empty", r_empty, 1);

    // 5 streaming 40 writes/reads across the pointer wrap
    do_reset();
    wb           = 5'd0;
    addr_wrapped = 1'b0;
    gptr_wrapped = 1'b0;
    bad_level    = 0;
    bad_empty    = 0;
    r_en         = 1'b1;
    for (int i = 0; i < 52; i++) begin
      if (i < 40) begin
        wb     = wb + 5'd1;
        w_gptr = wb ^ (wb >> 1);
      end
      prev_addr = r_addr;
      prev_gptr = r_gptr;
      tick();
      if (prev_addr == 4'd15 && r_addr == 4'd0) addr_wrapped = 1'b1;
      if (prev_gptr == 5'b10000 && r_gptr == 5'b00000) gptr_wrapped = 1'b1;
      if (r_level > 5'd16) bad_level++;
      if (r_empty != (r_level == 5'd0)) bad_empty++;
    end
    r_en = 1'b0;
    check("wrap_addr_seen", addr_wrapped, 1);
    check("wrap_gptr_seen", gptr_wrapped, 1);
    check("wrap_level_le16", bad_level, 0);
    check("wrap_empty_inv", bad_empty, 0);
    check("wrap_final_addr", r_addr, 8);
    check("wrap_final_gptr", r_gptr, 5'b01100);
    check("wrap_final_empty", r_empty, 1);

    // 6 reset in the middle of operation
    do_reset();
    w_gptr = 5'b00100;
    tick();
    tick();
    tick();
    check("mid_level", r_level, 7);
    r_rst  = 1'b1;
    r_en   = 1'b1;
    w_gptr = 5'd0;
    tick();
    check("midrst_empty", r_empty, 1);
    check("midrst_level", r_level, 0);
    check("midrst_addr", r_addr, 0);
    check("midrst_gptr", r_gptr, 0);
    tick();
    r_rst = 1'b0;
    r_en  = 1'b0;
    tick();
    check("post_rst_addr", r_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
